// File: rtl/snn_weight_config_ctrl.sv
// snn_weight_config_ctrl
// Host-side controller for the weight memories of an integrate-and-fire neuron
// array. Serves one read/write request at a time over valid/ready, drives a
// shared registered address/data bus with a one-hot per-neuron write enable,
// returns a response per request, and runs a broadcast-init that loads one
// weight into every synapse of every neuron.
module snn_weight_config_ctrl #(
  parameter int NUM_NEURONS       = 4,
  parameter int NUM_INPUTS        = 4,
  parameter int WEIGHT_SIZE       = 32,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter int NEURON_ID_WIDTH   = 2
) (
  input  logic                               mem_clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [NEURON_ID_WIDTH-1:0]         req_neuron,
  input  logic [WEIGHT_ADDR_WIDTH-1:0]       req_addr,
  input  logic [WEIGHT_SIZE-1:0]             req_data,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [WEIGHT_SIZE-1:0]             rsp_data,
  output logic                               rsp_err,
  input  logic                               init_start,
  input  logic [WEIGHT_SIZE-1:0]             init_weight,
  output logic                               busy,
  output logic [WEIGHT_ADDR_WIDTH-1:0]       mem_addr,
  output logic [WEIGHT_SIZE-1:0]             mem_din,
  output logic [NUM_NEURONS-1:0]             mem_wen,
  input  logic [NUM_NEURONS*WEIGHT_SIZE-1:0] mem_dout_bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    INIT
  } state_t;

  localparam logic [31:0] NEURON_LIMIT = NUM_NEURONS;
  localparam logic [31:0] INPUT_LIMIT  = NUM_INPUTS;
  localparam logic [WEIGHT_ADDR_WIDTH-1:0] LAST_ADDR = WEIGHT_ADDR_WIDTH'(NUM_INPUTS - 1);

  state_t                         state, state_nxt;
  logic [NEURON_ID_WIDTH-1:0]     lat_neuron, lat_neuron_nxt;
  logic                           lat_write, lat_write_nxt;
  logic [WEIGHT_ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [WEIGHT_SIZE-1:0]         mem_din_nxt;
  logic [NUM_NEURONS-1:0]         mem_wen_nxt;
  logic [WEIGHT_SIZE-1:0]         rsp_data_nxt;
  logic                           rsp_err_nxt;
  logic                           req_in_range;
  logic [NUM_NEURONS-1:0]         req_onehot;
  logic [WEIGHT_SIZE-1:0]         dout_sel;

  // Init takes priority over a request arriving in the same cycle.
  assign req_ready    = (state == IDLE) && !init_start;
  assign rsp_valid    = (state == RESP);
  // Full-width range check so wide ids/addresses never alias onto valid ones.
  assign req_in_range = (32'(req_neuron) < NEURON_LIMIT) && (32'(req_addr) < INPUT_LIMIT);

  // Decode the request neuron to a write-enable mask and pick the latched neuron's read data.
  always_comb begin
    req_onehot = '0;
    dout_sel   = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      req_onehot[n] = (req_neuron == NEURON_ID_WIDTH'(n));
      if (lat_neuron == NEURON_ID_WIDTH'(n)) begin
        dout_sel = mem_dout_bus[n*WEIGHT_SIZE +: WEIGHT_SIZE];
      end
    end
  end

  // Next-state and next-output logic; bus values hold unless a state updates them.
  always_comb begin
    state_nxt      = state;
    lat_neuron_nxt = lat_neuron;
    lat_write_nxt  = lat_write;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    mem_wen_nxt    = '0;
    rsp_data_nxt   = rsp_data;
    rsp_err_nxt    = rsp_err;
    case (state)
      IDLE: begin
        if (init_start) begin
          state_nxt    = INIT;
          mem_addr_nxt = '0;
          mem_din_nxt  = init_weight;
          mem_wen_nxt  = '1;
        end else if (req_valid) begin
          lat_neuron_nxt = req_neuron;
          lat_write_nxt  = req_write;
          if (!req_in_range) begin
            state_nxt    = RESP;
            rsp_err_nxt  = 1'b1;
            rsp_data_nxt = '0;
          end else begin
            state_nxt    = ISSUE;
            mem_addr_nxt = req_addr;
            if (req_write) begin
              mem_din_nxt = req_data;
              mem_wen_nxt = req_onehot;
            end
          end
        end
      end
      ISSUE: begin
        if (lat_write) begin
          state_nxt    = RESP;
          rsp_data_nxt = '0;
          rsp_err_nxt  = 1'b0;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt    = RESP;
        rsp_data_nxt = dout_sel;
        rsp_err_nxt  = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      INIT: begin
        if (mem_addr == LAST_ADDR) begin
          state_nxt = IDLE;
        end else begin
          mem_addr_nxt = mem_addr + 1'b1;
          mem_wen_nxt  = '1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction and drops the write enable.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_neuron <= '0;
      lat_write  <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wen    <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_neuron <= lat_neuron_nxt;
      lat_write  <= lat_write_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      mem_wen    <= mem_wen_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_err    <= rsp_err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_snn_weight_config_ctrl.sv
// Testbench for snn_weight_config_ctrl: behavioural 1-cycle neuron memories,
// table-driven request vectors, and hand-written backpressure, broadcast-init
// and reset-during-init sequences.
module tb_snn_weight_config_ctrl;

  localparam int NN  = 4;
  localparam int NI  = 4;
  localparam int WS  = 32;
  localparam int AW  = 8;
  localparam int IDW = 3;

  logic            mem_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [IDW-1:0]  req_neuron = '0;
  logic [AW-1:0]   req_addr = '0;
  logic [WS-1:0]   req_data = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [WS-1:0]   rsp_data;
  logic            rsp_err;
  logic            init_start = 1'b0;
  logic [WS-1:0]   init_weight = '0;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic [WS-1:0]   mem_din;
  logic [NN-1:0]   mem_wen;
  logic [NN*WS-1:0] mem_dout_bus;

  logic [WS-1:0]   wmem [NN][NI] = '{default: '0};
  logic [WS-1:0]   dout [NN] = '{default: '0};

  typedef struct {
    logic           wr;
    logic [IDW-1:0] neuron;
    logic [AW-1:0]  addr;
    logic [WS-1:0]  data;
    logic           exp_err;
    logic [WS-1:0]  exp_data;
    int             exp_lat;
    logic [NN-1:0]  exp_wen;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;

  snn_weight_config_ctrl #(
    .NUM_NEURONS(NN),
    .NUM_INPUTS(NI),
    .WEIGHT_SIZE(WS),
    .WEIGHT_ADDR_WIDTH(AW),
    .NEURON_ID_WIDTH(IDW)
  ) dut (
    .mem_clk(mem_clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_neuron(req_neuron),
    .req_addr(req_addr),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .init_start(init_start),
    .init_weight(init_weight),
    .busy(busy),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_wen(mem_wen),
    .mem_dout_bus(mem_dout_bus)
  );

  // Free-running clock.
  always #5 mem_clk = ~mem_clk;

  // Behavioural neuron memories: synchronous write, 1-cycle registered read.
  always @(posedge mem_clk) begin
    for (int n = 0; n < NN; n++) begin
      if (mem_wen[n] && (mem_addr < NI)) wmem[n][mem_addr[1:0]] <= mem_din;
      dout[n] <= (mem_addr < NI) ? wmem[n][mem_addr[1:0]] : '0;
    end
  end

  // Pack per-neuron read data onto the shared bus.
  always_comb begin
    mem_dout_bus = '0;
    for (int n = 0; n < NN; n++) mem_dout_bus[n*WS +: WS] = dout[n];
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkvec(input logic wr, input logic [IDW-1:0] n, input logic [AW-1:0] a,
                                 input logic [WS-1:0] d, input logic err, input logic [WS-1:0] ed,
                                 input int lat, input logic [NN-1:0] wen);
    vec_t v;
    v.wr = wr; v.neuron = n; v.addr = a; v.data = d;
    v.exp_err = err; v.exp_data = ed; v.exp_lat = lat; v.exp_wen = wen;
    return v;
  endfunction

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Called in cycle 1 after an accept; follows the transaction until rsp_valid or budget expiry.
  task automatic waitResponse(output int lat, output logic [NN-1:0] wen_or, output int wen_cycles,
                              output logic [AW-1:0] wen_addr, output logic [WS-1:0] wen_din);
    lat = -1; wen_or = '0; wen_cycles = 0; wen_addr = '0; wen_din = '0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_wen != '0) begin
        wen_or |= mem_wen;
        wen_cycles++;
        wen_addr = mem_addr;
        wen_din = mem_din;
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    int wen_cycles;
    logic [NN-1:0] wen_or;
    logic [AW-1:0] wen_addr;
    logic [WS-1:0] wen_din;
    req_write = v.wr;
    req_neuron = v.neuron;
    req_addr = v.addr;
    req_data = v.data;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    waitResponse(lat, wen_or, wen_cycles, wen_addr, wen_din);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    checkOutput({tag, ".rsp_data"}, rsp_data, v.exp_data);
    checkOutput({tag, ".wen_mask"}, 32'(wen_or), 32'(v.exp_wen));
    checkOutput({tag, ".wen_cycles"}, 32'(wen_cycles), (v.exp_wen != '0) ? 32'd1 : 32'd0);
    if (v.exp_wen != '0) begin
      checkOutput({tag, ".wen_addr"}, 32'(wen_addr), 32'(v.addr));
      checkOutput({tag, ".wen_din"}, wen_din, v.data);
    end
    tick();
    checkOutput({tag, ".idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".rsp_data"}, rsp_data, 32'd0);
    checkOutput({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, ".mem_din"}, mem_din, 32'd0);
    checkOutput({tag, ".mem_wen"}, 32'(mem_wen), 32'd0);
  endtask

  initial begin
    int lat;
    int wen_cycles;
    logic [NN-1:0] wen_or;
    logic [AW-1:0] wen_addr;
    logic [WS-1:0] wen_din;

    vecs[0] = mkvec(1'b1, 3'd2, 8'd3,   32'hDEADBEEF, 1'b0, 32'h0,        2, 4'b0100);
    vecs[1] = mkvec(1'b0, 3'd2, 8'd3,   32'h0,        1'b0, 32'hDEADBEEF, 3, 4'b0000);
    vecs[2] = mkvec(1'b0, 3'd0, 8'd3,   32'h0,        1'b0, 32'h0,        3, 4'b0000);
    vecs[3] = mkvec(1'b1, 3'd1, 8'd0,   32'h12345678, 1'b0, 32'h0,        2, 4'b0010);
    vecs[4] = mkvec(1'b0, 3'd1, 8'd0,   32'h0,        1'b0, 32'h12345678, 3, 4'b0000);
    vecs[5] = mkvec(1'b1, 3'd4, 8'd0,   32'hCAFEF00D, 1'b1, 32'h0,        1, 4'b0000);
    vecs[6] = mkvec(1'b0, 3'd0, 8'd4,   32'h0,        1'b1, 32'h0,        1, 4'b0000);
    vecs[7] = mkvec(1'b1, 3'd3, 8'd255, 32'hA5A5A5A5, 1'b1, 32'h0,        1, 4'b0000);
    vecs[8] = mkvec(1'b0, 3'd1, 8'd3,   32'h0,        1'b0, 32'h0,        3, 4'b0000);
    vecs[9] = mkvec(1'b0, 3'd3, 8'd3,   32'h0,        1'b0, 32'h0,        3, 4'b0000);

    // Reset state.
    #2;
    checkResetOutputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Table-driven requests.
    for (int i = 0; i < NV; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held for 5 cycles while a new request waits.
    req_write = 1'b0; req_neuron = 3'd2; req_addr = 8'd3; req_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    tick();
    req_valid = 1'b0;
    waitResponse(lat, wen_or, wen_cycles, wen_addr, wen_din);
    checkOutput("bp.latency", 32'(lat), 32'd3);
    req_write = 1'b1; req_neuron = 3'd0; req_addr = 8'd0; req_data = 32'h11111111; req_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      #1;
      checkOutput($sformatf("bp.rsp_valid%0d", h), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp.rsp_data%0d", h), rsp_data, 32'hDEADBEEF);
      checkOutput($sformatf("bp.rsp_err%0d", h), 32'(rsp_err), 32'd0);
      checkOutput($sformatf("bp.req_ready%0d", h), 32'(req_ready), 32'd0);
      checkOutput($sformatf("bp.mem_wen%0d", h), 32'(mem_wen), 32'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    tick();
    checkOutput("bp.released", 32'(rsp_valid), 32'd0);
    checkOutput("bp.released_wen", 32'(mem_wen), 32'd0);
    applyStimulus(mkvec(1'b0, 3'd0, 8'd0, 32'h0, 1'b0, 32'h0, 3, 4'b0000), "bp.noleak");

    // Broadcast init racing a request; init wins, request waits for busy to fall.
    req_write = 1'b0; req_neuron = 3'd0; req_addr = 8'd1; req_valid = 1'b1; rsp_ready = 1'b1;
    init_start = 1'b1; init_weight = 32'd7;
    #1;
    checkOutput("init.req_ready0", 32'(req_ready), 32'd0);
    tick();
    init_start = 1'b0;
    init_weight = 32'hFFFF0000;
    for (int k = 0; k < NI; k++) begin
      #1;
      checkOutput($sformatf("init.wen%0d", k), 32'(mem_wen), 32'hF);
      checkOutput($sformatf("init.addr%0d", k), 32'(mem_addr), 32'(k));
      checkOutput($sformatf("init.din%0d", k), mem_din, 32'd7);
      checkOutput($sformatf("init.busy%0d", k), 32'(busy), 32'd1);
      checkOutput($sformatf("init.ready%0d", k), 32'(req_ready), 32'd0);
      tick();
    end
    #1;
    checkOutput("init.done_busy", 32'(busy), 32'd0);
    checkOutput("init.done_wen", 32'(mem_wen), 32'd0);
    checkOutput("init.done_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    waitResponse(lat, wen_or, wen_cycles, wen_addr, wen_din);
    checkOutput("init.held_latency", 32'(lat), 32'd3);
    checkOutput("init.held_data", rsp_data, 32'd7);
    tick();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NI; a++)
        applyStimulus(mkvec(1'b0, IDW'(n), AW'(a), 32'h0, 1'b0, 32'd7, 3, 4'b0000),
                      $sformatf("init.rd_n%0d_a%0d", n, a));

    // Reset during init while address 2 is on the bus.
    init_weight = 32'h55;
    init_start = 1'b1;
    #1;
    tick();
    init_start = 1'b0;
    tick();
    tick();
    checkOutput("rinit.addr", 32'(mem_addr), 32'd2);
    checkOutput("rinit.wen", 32'(mem_wen), 32'hF);
    rst_n = 1'b0;
    #1;
    checkOutput("rinit.wen_drop", 32'(mem_wen), 32'd0);
    checkOutput("rinit.busy_drop", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkResetOutputs("rinit.after");
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < 3; a++)
        applyStimulus(mkvec(1'b0, IDW'(n), AW'(a), 32'h0, 1'b0, (a < 2) ? 32'h55 : 32'd7, 3, 4'b0000),
                      $sformatf("rinit.rd_n%0d_a%0d", n, a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_weight_config_ctrl.md
# snn_weight_config_ctrl

Host-side controller that owns the weight-memory ports of an array of `NUM_NEURONS` integrate-and-fire neurons. It accepts one read or write request at a time over a valid/ready handshake and decodes it to a shared address/data bus with a one-hot per-neuron write enable. It returns each read result or write acknowledgement over a valid/ready response channel. A broadcast-init sequencer loads one weight value into every synapse of every neuron.

## Interface
- `NUM_NEURONS`, 4, neurons driven.
- `NUM_INPUTS`, 4, synapses (weight words) per neuron; valid addresses are 0..NUM_INPUTS-1.
- `WEIGHT_SIZE`, 32, weight word width.
- `WEIGHT_ADDR_WIDTH`, 8, neuron weight-address width.
- `NEURON_ID_WIDTH`, 2, neuron select width; must be ≥ clog2(NUM_NEURONS).

Ports:
- `mem_clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1; `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_neuron` in NEURON_ID_WIDTH: target neuron.
- `req_addr` in WEIGHT_ADDR_WIDTH: synapse index.
- `req_data` in WEIGHT_SIZE: write data.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_data` out WEIGHT_SIZE: read data; 0 for writes and errors.
- `rsp_err` out 1: out-of-range neuron or address.
- `init_start` in 1: single-cycle broadcast-init trigger.
- `init_weight` in WEIGHT_SIZE: value to broadcast.
- `busy` out 1: high while not IDLE.
- `mem_addr` out WEIGHT_ADDR_WIDTH; `mem_din` out WEIGHT_SIZE: shared bus to all neurons, registered.
- `mem_wen` out NUM_NEURONS: one-hot per-neuron write enable, registered.
- `mem_dout_bus` in NUM_NEURONS*WEIGHT_SIZE: neuron n read data in bits [n*WEIGHT_SIZE +: WEIGHT_SIZE]. Each neuron memory has 1-cycle synchronous read latency.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP, INIT.
- `req_ready` = (state==IDLE) && !init_start; this is combinational. Only one transaction is outstanding at a time.
- IDLE, `init_start`=1:
  - Go to INIT; `init_weight` is latched.
  - `init_start` has priority over a simultaneous `req_valid`; that request is not accepted.
- IDLE, accept (`req_valid && req_ready`): latch neuron, addr, data, and write.
  - Out of range (`req_neuron`≥NUM_NEURONS or `req_addr`≥NUM_INPUTS, full-width compare): go to RESP with `rsp_err`=1 and `rsp_data`=0. No memory access occurs.
  - Write: go to ISSUE with `mem_wen[neuron]`=1 for exactly that cycle, then go to RESP with `rsp_data`=0 and `rsp_err`=0.
  - Read: go to ISSUE with `mem_wen`=0 and `mem_addr` driven, then CAPTURE. In CAPTURE, the selected `mem_dout_bus` slice is registered into `rsp_data`. Then go to RESP.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_ready`=1, after which the state returns to IDLE on the next cycle.
- INIT: walks `mem_addr` from 0 to NUM_INPUTS-1, one address per cycle, with `mem_wen` all ones and `mem_din`=latched weight. After the last address it returns to IDLE. INIT produces no response.
- `init_start` outside IDLE is ignored.
- `mem_addr` and `mem_din` hold their last values when idle. `mem_wen` is 0 whenever not writing.

## Timing
- Reset (async, `rst_n`=0): state IDLE. `req_ready`=1 (subject to `init_start`); all other outputs 0 (`rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `mem_addr`, `mem_din`, `mem_wen`).
- Reset asserted mid-transaction or mid-INIT: `mem_wen` drops immediately and the transaction is aborted with no response. Writes already completed persist.
- Cycle numbering: accept edge ends cycle 0.
  - Write: `mem_wen` high in cycle 1; `rsp_valid` from cycle 2.
  - Read: `mem_addr` valid in cycle 1; data is captured at the end of cycle 2; `rsp_valid` from cycle 3.
  - Error: `rsp_valid` from cycle 1.
- Back-to-back requests: the minimum spacing between accepts is response latency + 1 (the IDLE cycle).
- INIT: triggered at the edge ending cycle 0. Writes occur in cycles 1..NUM_INPUTS; `busy` is high in cycles 1..NUM_INPUTS; `req_ready` returns in cycle NUM_INPUTS+1.
- `busy` = (state != IDLE), registered.

## Test plan
- Write neuron 2, addr 3, data 0xDEADBEEF, with `rsp_ready`=1: `mem_wen`=4'b0100 for exactly one cycle with `mem_addr`=3 and `mem_din`=0xDEADBEEF; ack with `rsp_data`=0 and `rsp_err`=0 two cycles after accept.
- Read back neuron 2, addr 3 from a behavioural 1-cycle memory: `rsp_valid` three cycles after accept with `rsp_data`=0xDEADBEEF. Other neurons' memories are unchanged.
- Requests with `req_neuron`=4 (NUM_NEURONS=4) and with `req_addr`=4: `rsp_err`=1, `rsp_data`=0, `mem_wen` never asserted.
- `init_start` with `init_weight`=7, same cycle as `req_valid`: `req_ready`=0; four cycles with `mem_wen`=4'hF and addresses 0,1,2,3. Afterwards every read returns 7. The held request is accepted only after `busy` falls.
- Hold `rsp_ready`=0 for 5 cycles on a read: `rsp_valid`, `rsp_data`, and `rsp_err` stay stable, `req_ready`=0, and no new `mem_wen` occurs.
- Assert `rst_n`=0 during INIT at addr 2: `mem_wen`=0 immediately. After release, all outputs are 0 and `req_ready`=1; addresses 0–1 hold the init value.
